// File: rtl/mcu_mux_array_if.sv
// Bus bundle between the MCU sequencer and the line-memory / convolver mux array.
// Select widths use "bits to represent x" (floor(log2 x)+1), i.e. $clog2(x+1).
interface mcu_mux_array_if #(
  parameter int N           = 4,
  parameter int BITS_IMAGEN = 8,
  parameter int BITS_DATA   = 13,
  parameter int STATES      = 3
);
  localparam int STATE_W = $clog2(STATES);
  localparam int SUB_W   = $clog2(N/2 + 1);
  localparam int SEL_W   = $clog2(N + 2);

  logic [N*BITS_DATA-1:0]       i_DataConv;
  logic [(N+2)*BITS_DATA-1:0]   i_MemData;
  logic [BITS_IMAGEN-1:0]       i_Data;
  logic [STATE_W-1:0]           i_state;
  logic [SUB_W-1:0]             i_substate;
  logic [SEL_W-1:0]             i_memSelect;
  logic [3*N*BITS_IMAGEN-1:0]   o_DataConv;
  logic [(N+2)*BITS_DATA-1:0]   o_MemData;
  logic [BITS_DATA-1:0]         o_Data;

  modport master (
    output i_DataConv, i_MemData, i_Data, i_state, i_substate, i_memSelect,
    input  o_DataConv, o_MemData, o_Data
  );

  modport slave (
    input  i_DataConv, i_MemData, i_Data, i_state, i_substate, i_memSelect,
    output o_DataConv, o_MemData, o_Data
  );
endinterface

// File: rtl/mcu_mux_array.sv
// Registered routing between N+2 line memories, N convolvers and the host,
// steered by the MCU state (LOAD / CONV / READ / idle); one-cycle latency.
module mcu_mux_array #(
  parameter int N           = 4,
  parameter int BITS_IMAGEN = 8,
  parameter int BITS_DATA   = 13,
  parameter int STATES      = 3
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  mcu_mux_array_if.slave  bus
);
  localparam int SLOTS   = N + 2;
  localparam int ST_LOAD = 0;
  localparam int ST_CONV = 1;
  localparam int ST_READ = 2;

  logic [BITS_DATA-1:0]       mem_in [SLOTS];
  logic [BITS_DATA-1:0]       px_ext;
  logic [3*N*BITS_IMAGEN-1:0] win_p0;
  logic [SLOTS*BITS_DATA-1:0] mem_p0;
  logic [BITS_DATA-1:0]       data_p0;
  int                         state_i;
  int                         sel_i;
  int                         off;

  function automatic logic [BITS_IMAGEN-1:0] pixel_of(input logic [BITS_DATA-1:0] w);
    return w[BITS_IMAGEN-1:0];
  endfunction

  // Callers never exceed 2*SLOTS-1, so one conditional subtract is a full wrap.
  function automatic int wrap_slot(input int idx);
    return (idx >= SLOTS) ? idx - SLOTS : idx;
  endfunction

  for (genvar k = 0; k < SLOTS; k++) begin : g_unpack
    assign mem_in[k] = bus.i_MemData[k*BITS_DATA +: BITS_DATA];
  end

  // Stage p0: combinational next-value selection from current inputs
  always_comb begin
    win_p0  = '0;
    mem_p0  = '0;
    data_p0 = '0;
    px_ext  = '0;
    px_ext[BITS_IMAGEN-1:0] = bus.i_Data;
    state_i = int'(bus.i_state);
    sel_i   = int'(bus.i_memSelect);
    off     = (2 * int'(bus.i_substate)) % SLOTS;
    if (state_i == ST_LOAD) begin
      for (int k = 0; k < SLOTS; k++) begin
        if (sel_i == k) mem_p0[k*BITS_DATA +: BITS_DATA] = px_ext;
      end
    end else if (state_i == ST_CONV) begin
      for (int j = 0; j < N; j++) begin
        for (int t = 0; t < 3; t++) begin
          win_p0[(3*j+t)*BITS_IMAGEN +: BITS_IMAGEN] = pixel_of(mem_in[wrap_slot(off + j + t)]);
        end
      end
      mem_p0[N*BITS_DATA-1:0] = bus.i_DataConv;
    end else if (state_i == ST_READ && state_i < STATES) begin
      for (int k = 0; k < SLOTS; k++) begin
        if (sel_i == k) data_p0 = mem_in[k];
      end
    end
  end

  // Stage p1: output registers, cleared asynchronously
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      bus.o_DataConv <= '0;
      bus.o_MemData  <= '0;
      bus.o_Data     <= '0;
    end else begin
      bus.o_DataConv <= win_p0;
      bus.o_MemData  <= mem_p0;
      bus.o_Data     <= data_p0;
    end
  end
endmodule

// File: tb/tb_mcu_mux_array.sv
// Directed, table-driven bench for mcu_mux_array at default parameters (N=4).
module tb_mcu_mux_array;
  localparam int N = 4;
  localparam int BI = 8;
  localparam int BD = 13;
  localparam int DCW = N*BD;
  localparam int MW  = (N+2)*BD;
  localparam int WW  = 3*N*BI;

  typedef logic [BI-1:0] win_arr_t  [12];
  typedef logic [BD-1:0] mem_arr_t  [N+2];
  typedef logic [BD-1:0] conv_arr_t [N];

  typedef struct {
    string            name;
    logic [1:0]       state;
    logic [1:0]       sub;
    logic [2:0]       sel;
    logic [BI-1:0]    data;
    logic [DCW-1:0]   dconv;
    logic [MW-1:0]    mem;
    logic [WW-1:0]    exp_win;
    logic [MW-1:0]    exp_mem;
    logic [BD-1:0]    exp_data;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vq[$];

  mcu_mux_array_if #(.N(N), .BITS_IMAGEN(BI), .BITS_DATA(BD), .STATES(3)) bus ();

  mcu_mux_array #(.N(N), .BITS_IMAGEN(BI), .BITS_DATA(BD), .STATES(3)) dut (
    .i_CLK (clk),
    .i_RST (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [WW-1:0] mkwin(input win_arr_t p);
    logic [WW-1:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) r[i*BI +: BI] = p[i];
    return r;
  endfunction

  function automatic logic [MW-1:0] mkmem(input mem_arr_t m);
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < N+2; i++) r[i*BD +: BD] = m[i];
    return r;
  endfunction

  function automatic logic [DCW-1:0] mkconv(input conv_arr_t c);
    logic [DCW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*BD +: BD] = c[i];
    return r;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [WW-1:0] w, input logic [MW-1:0] m,
                           input logic [BD-1:0] d);
    check({nm, ".o_DataConv"}, 128'(bus.o_DataConv), 128'(w));
    check({nm, ".o_MemData"},  128'(bus.o_MemData),  128'(m));
    check({nm, ".o_Data"},     128'(bus.o_Data),     128'(d));
  endtask

  task automatic drive(input vec_t v);
    bus.i_state     = v.state;
    bus.i_substate  = v.sub;
    bus.i_memSelect = v.sel;
    bus.i_Data      = v.data;
    bus.i_DataConv  = v.dconv;
    bus.i_MemData   = v.mem;
  endtask

  task automatic add(input string nm, input logic [1:0] st, input logic [1:0] sb, input logic [2:0] sl,
                     input logic [BI-1:0] dt, input logic [DCW-1:0] dc, input logic [MW-1:0] mm,
                     input logic [WW-1:0] ew, input logic [MW-1:0] em, input logic [BD-1:0] ed);
    vec_t v;
    v.name = nm; v.state = st; v.sub = sb; v.sel = sl; v.data = dt; v.dconv = dc; v.mem = mm;
    v.exp_win = ew; v.exp_mem = em; v.exp_data = ed;
    vq.push_back(v);
  endtask

  initial begin
    logic [MW-1:0]  def_mem, ff_mem, wide_mem, m_dc, m_dc2;
    logic [DCW-1:0] dc, dc2;
    logic [WW-1:0]  w0, w1, w2, wff;
    vec_t           v;

    checks = 0;
    failures = 0;

    def_mem  = mkmem('{13'd1, 13'd2, 13'd3, 13'd4, 13'd5, 13'd6});
    ff_mem   = mkmem('{13'h1FF, 13'd2, 13'd3, 13'd4, 13'd5, 13'd6});
    wide_mem = mkmem('{13'd1, 13'd2, 13'h1ABC, 13'd4, 13'd5, 13'd6});
    dc       = mkconv('{13'd0, 13'd1, 13'd2, 13'd3});
    dc2      = mkconv('{13'h1FFF, 13'h100, 13'd0, 13'hABC});
    m_dc     = mkmem('{13'd0, 13'd1, 13'd2, 13'd3, 13'd0, 13'd0});
    m_dc2    = mkmem('{13'h1FFF, 13'h100, 13'd0, 13'hABC, 13'd0, 13'd0});
    w0  = mkwin('{8'd1, 8'd2, 8'd3, 8'd2, 8'd3, 8'd4, 8'd3, 8'd4, 8'd5, 8'd4, 8'd5, 8'd6});
    w1  = mkwin('{8'd3, 8'd4, 8'd5, 8'd4, 8'd5, 8'd6, 8'd5, 8'd6, 8'd1, 8'd6, 8'd1, 8'd2});
    w2  = mkwin('{8'd5, 8'd6, 8'd1, 8'd6, 8'd1, 8'd2, 8'd1, 8'd2, 8'd3, 8'd2, 8'd3, 8'd4});
    wff = mkwin('{8'hFF, 8'd2, 8'd3, 8'd2, 8'd3, 8'd4, 8'd3, 8'd4, 8'd5, 8'd4, 8'd5, 8'd6});

    add("load_sel3", 2'd0, 2'd0, 3'd3, 8'hAA, dc, def_mem, '0,
        mkmem('{13'd0, 13'd0, 13'd0, 13'h0AA, 13'd0, 13'd0}), '0);
    add("load_sel6", 2'd0, 2'd0, 3'd6, 8'hAA, dc, def_mem, '0, '0, '0);
    add("load_sel0", 2'd0, 2'd1, 3'd0, 8'h05, dc, def_mem, '0,
        mkmem('{13'h005, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0}), '0);
    add("load_sel5", 2'd0, 2'd0, 3'd5, 8'hFF, dc, def_mem, '0,
        mkmem('{13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'h0FF}), '0);
    add("load_sel7", 2'd0, 2'd0, 3'd7, 8'h33, dc, def_mem, '0, '0, '0);
    add("conv_sub0", 2'd1, 2'd0, 3'd2, 8'h11, dc,  def_mem, w0, m_dc,  '0);
    add("conv_sub1", 2'd1, 2'd1, 3'd0, 8'h11, dc2, def_mem, w1, m_dc2, '0);
    add("conv_sub2", 2'd1, 2'd2, 3'd5, 8'h11, dc,  def_mem, w2, m_dc,  '0);
    add("conv_sub3", 2'd1, 2'd3, 3'd1, 8'h11, dc2, def_mem, w0, m_dc2, '0);
    add("conv_ff",   2'd1, 2'd0, 3'd0, 8'h11, dc,  ff_mem,  wff, m_dc, '0);
    add("read_sel4", 2'd2, 2'd1, 3'd4, 8'h77, dc, def_mem, '0, '0, 13'd5);
    add("read_sel7", 2'd2, 2'd0, 3'd7, 8'h77, dc, def_mem, '0, '0, 13'd0);
    add("read_sel5", 2'd2, 2'd0, 3'd5, 8'h77, dc, def_mem, '0, '0, 13'd6);
    add("read_wide", 2'd2, 2'd0, 3'd2, 8'h77, dc, wide_mem, '0, '0, 13'h1ABC);
    add("idle",      2'd3, 2'd1, 3'd2, 8'h77, dc, def_mem, '0, '0, '0);
    add("conv_sub1b",2'd1, 2'd1, 3'd0, 8'h00, dc, def_mem, w1, m_dc, '0);
    add("read_sel0", 2'd2, 2'd1, 3'd0, 8'h00, dc, def_mem, '0, '0, 13'd1);

    // reset held low while inputs toggle across edges
    rst_n = 1'b0;
    v = vq[5];
    drive(v);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_all($sformatf("reset_hold%0d", i), '0, '0, '0);
      v = vq[(i * 5 + 3) % vq.size()];
      drive(v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_state = 2'd2; bus.i_memSelect = 3'd0; bus.i_MemData = def_mem;
    @(posedge clk); #1;
    check("release_read0", 128'(bus.o_Data), 128'(13'd1));

    // table vectors
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      @(posedge clk); #1;
      check_all(vq[i].name, vq[i].exp_win, vq[i].exp_mem, vq[i].exp_data);
    end

    // outputs must hold between edges while inputs change
    @(negedge clk);
    bus.i_state = 2'd2; bus.i_memSelect = 3'd4; bus.i_MemData = def_mem;
    @(posedge clk); #1;
    check("hold_pre", 128'(bus.o_Data), 128'(13'd5));
    #2;
    bus.i_memSelect = 3'd1;
    #1;
    check("hold_mid", 128'(bus.o_Data), 128'(13'd5));
    @(posedge clk); #1;
    check("hold_post", 128'(bus.o_Data), 128'(13'd2));

    // asynchronous reset in the middle of a CONV cycle
    @(negedge clk);
    drive(vq[5]);
    @(posedge clk); #1;
    check_all("conv_before_rst", w0, m_dc, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", '0, '0, '0);
    @(posedge clk); #1;
    check_all("rst_over_edge", '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(vq[6]);
    @(posedge clk); #1;
    check_all("after_rst", w1, m_dc2, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mcu_mux_array.md
MCU_MUX_ARRAY -- requirements
Module: mcu_mux_array

Interface
REQ-001 Parameter N, default 4: number of convolvers, even, >=2; N+2 line memories.
REQ-002 Parameter BITS_IMAGEN, default 8: pixel width.
REQ-003 Parameter BITS_DATA, default 13: memory word / convolver result width, >= BITS_IMAGEN.
REQ-004 Parameter STATES, default 3: number of MCU states.
REQ-005 clog2(x) SHALL mean bits needed to represent x, i.e. floor(log2 x)+1; clog2(2)=2, clog2(5)=3.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 i_CLK  in  1  clock; all outputs update on rising edge.
REQ-008 i_RST  in  1  asynchronous active-low reset.
REQ-009 i_DataConv  in  N*BITS_DATA  convolver results; result j at bits [j*BITS_DATA +: BITS_DATA].
REQ-010 i_MemData  in  (N+2)*BITS_DATA  memory read words; slot k at [k*BITS_DATA +: BITS_DATA].
REQ-011 i_Data  in  BITS_IMAGEN  pixel from host.
REQ-012 i_state  in  clog2(STATES-1)  0=LOAD, 1=CONV, 2=READ, 3=idle.
REQ-013 i_substate  in  clog2(N/2)  CONV rotation index.
REQ-014 i_memSelect  in  clog2(N+1)  memory slot select, valid 0..N+1.
REQ-015 o_DataConv  out  3*N*BITS_IMAGEN  convolver j window at [3*j*BITS_IMAGEN +: 3*BITS_IMAGEN].
REQ-016 o_MemData  out  (N+2)*BITS_DATA  memory write words, slot layout as i_MemData.
REQ-017 o_Data  out  BITS_DATA  word returned to host.

Function
REQ-018 All outputs SHALL be registered: value computed from current inputs appears after next rising i_CLK (latency 1), no combinational path input->output.
REQ-019 Pixel of a memory word SHALL be its low BITS_IMAGEN bits (upper bits discarded).
REQ-020 LOAD (i_state=0): o_MemData slot i_memSelect = i_Data zero-extended to BITS_DATA, all other slots 0; i_memSelect>N+1 -> all slots 0; o_DataConv=0; o_Data=0.
REQ-021 CONV (i_state=1): offset = (2*i_substate) mod (N+2).
REQ-022 CONV: convolver j window = pixels of slots (offset+j), (offset+j+1), (offset+j+2), each mod (N+2), placed low-to-high in that order.
REQ-023 CONV: o_MemData slots 0..N-1 = i_DataConv results 0..N-1 unchanged; slots N, N+1 = 0; o_Data=0.
REQ-024 READ (i_state=2): o_Data = i_MemData slot i_memSelect; i_memSelect>N+1 -> 0; o_DataConv=0; o_MemData=0.
REQ-025 i_state=3 (and any value >=STATES): all outputs 0 next cycle.
REQ-026 i_substate values >=N/2 SHALL be accepted and handled by the modulo rule of REQ-021 (no error).
REQ-027 Changes of state/select take effect on the very next edge; no internal sequencing or history.

Reset
REQ-028 i_RST low SHALL immediately force o_DataConv, o_MemData, o_Data to 0, regardless of clock.
REQ-029 After i_RST rises, first rising edge SHALL load outputs per REQ-020..REQ-025 from current inputs.
REQ-030 Reset asserted mid-operation SHALL discard the current output without affecting later cycles.

Verification (N=4, defaults; slot k of i_MemData = k+1 unless stated)
REQ-031 Hold i_RST low, toggle inputs -> all outputs 0; release, state=2, memSelect=0 -> o_Data=1 after one edge.
REQ-032 LOAD, i_Data=0xAA, memSelect=3 -> o_MemData slot3=0x0AA, slots 0,1,2,4,5=0, o_DataConv=0, o_Data=0; memSelect=6 -> o_MemData=0.
REQ-033 CONV, substate=0, i_DataConv results {0,1,2,3} -> windows conv0={1,2,3}, conv3={4,5,6}; o_MemData slots 0..3={0,1,2,3}, slots 4,5=0.
REQ-034 CONV, substate=1 -> conv0={3,4,5}, conv3={6,1,2}; slot word 0x1FF -> pixel 0xFF.
REQ-035 READ, memSelect=4 -> o_Data=5; memSelect=7 -> o_Data=0; state=3 -> all outputs 0.
REQ-036 Assert i_RST between clock edges during CONV -> outputs 0 immediately, not waiting for edge.
